// File: rtl/conv_addr_sequencer_if.sv
// Host/control side of the convolution address sequencer: phase requests,
// block length and the address/strobe outputs toward line memories and convolver.
interface conv_addr_sequencer_if #(
  parameter int NB_ADDRESS = 10,
  parameter int NB_IMAGE   = 10,
  parameter int NB_BANK    = 2
);
  logic                  i_load;
  logic                  i_SoP;
  logic                  i_read;
  logic                  i_valid;
  logic [NB_IMAGE-1:0]   i_imgLength;
  logic [NB_ADDRESS-1:0] o_readAdd;
  logic [NB_ADDRESS-1:0] o_writeAdd;
  logic                  o_wr_en;
  logic                  o_valid_conv;
  logic [NB_BANK-1:0]    o_bank_sel;
  logic                  o_changeBlock;
  logic                  o_EoP;
  logic                  o_busy;
  logic [2:0]            o_state;

  modport master (
    output i_load, i_SoP, i_read, i_valid, i_imgLength,
    input  o_readAdd, o_writeAdd, o_wr_en, o_valid_conv, o_bank_sel,
           o_changeBlock, o_EoP, o_busy, o_state
  );

  modport slave (
    input  i_load, i_SoP, i_read, i_valid, i_imgLength,
    output o_readAdd, o_writeAdd, o_wr_en, o_valid_conv, o_bank_sel,
           o_changeBlock, o_EoP, o_busy, o_state
  );
endinterface

// File: rtl/conv_addr_sequencer.sv
// Address/phase controller for the 2D-convolution datapath: rotating bank load,
// pipelined convolution processing with result write-back, and result readout.
//
// state | meaning
// IDLE  | counters parked at 0, waiting for exactly one legal request
// LOAD  | host beats written into the selected line bank
// PROC  | read addresses 0..N-1 issued to the convolver, one per cycle
// DRAIN | waiting for the pipeline to write back the last result
// READ  | host beats read the result memory out
module conv_addr_sequencer #(
  parameter int NB_ADDRESS = 10,
  parameter int NB_IMAGE   = 10,
  parameter int N_BANKS    = 3,
  parameter int LATENCY    = 6,
  parameter int NB_BANK    = (N_BANKS > 1) ? $clog2(N_BANKS) : 1
) (
  input logic                  i_CLK,
  input logic                  i_reset,
  conv_addr_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    PROC  = 3'd2,
    DRAIN = 3'd3,
    READ  = 3'd4
  } state_t;

  localparam logic [NB_BANK-1:0] LAST_BANK = NB_BANK'(N_BANKS - 1);

  state_t                state;
  logic [NB_ADDRESS-1:0] lastIdx;
  logic [NB_ADDRESS-1:0] addrCnt;
  logic [NB_ADDRESS-1:0] wrCnt;
  logic [LATENCY-1:0]    validPipe;
  logic [NB_BANK-1:0]    bankSel;
  logic                  validConv;
  logic                  changeBlock;
  logic                  eop;

  logic [NB_IMAGE-1:0]   imgLen;
  logic [NB_ADDRESS-1:0] lenFit;
  logic                  reqLoad;
  logic                  reqProc;
  logic                  reqRead;
  logic                  pipeOut;

  assign imgLen  = bus.i_imgLength;
  assign lenFit  = NB_ADDRESS'(imgLen);
  assign pipeOut = validPipe[LATENCY-1];

  // A request is only taken when it is the sole one raised and EoP permits it.
  assign reqLoad = bus.i_load & ~bus.i_SoP & ~bus.i_read & ~eop;
  assign reqProc = bus.i_SoP & ~bus.i_load & ~bus.i_read & ~eop;
  assign reqRead = bus.i_read & ~bus.i_load & ~bus.i_SoP & eop;

  always_ff @(posedge i_CLK or posedge i_reset) begin
    if (i_reset) begin
      state       <= IDLE;
      lastIdx     <= '0;
      addrCnt     <= '0;
      wrCnt       <= '0;
      validPipe   <= '0;
      bankSel     <= '0;
      validConv   <= 1'b0;
      changeBlock <= 1'b0;
      eop         <= 1'b0;
    end else begin
      changeBlock <= 1'b0;
      validPipe   <= (validPipe << 1) | LATENCY'(validConv);
      case (state)
        IDLE: begin
          addrCnt   <= '0;
          wrCnt     <= '0;
          validConv <= 1'b0;
          if (reqLoad) begin
            state   <= LOAD;
            lastIdx <= lenFit;
          end else if (reqProc) begin
            state     <= PROC;
            lastIdx   <= lenFit;
            validConv <= 1'b1;
          end else if (reqRead) begin
            state   <= READ;
            lastIdx <= lenFit;
          end
        end
        LOAD: begin
          if (bus.i_valid) begin
            if (addrCnt == lastIdx) begin
              addrCnt     <= '0;
              changeBlock <= 1'b1;
              bankSel     <= (bankSel == LAST_BANK) ? '0 : bankSel + 1'b1;
              state       <= IDLE;
            end else begin
              addrCnt <= addrCnt + 1'b1;
            end
          end
        end
        PROC: begin
          if (pipeOut) wrCnt <= wrCnt + 1'b1;
          // readAdd stays at N-1 through DRAIN, so the counter is not advanced on exit.
          if (addrCnt == lastIdx) begin
            validConv <= 1'b0;
            state     <= DRAIN;
          end else begin
            addrCnt <= addrCnt + 1'b1;
          end
        end
        DRAIN: begin
          if (pipeOut) begin
            if (wrCnt == lastIdx) begin
              eop     <= 1'b1;
              wrCnt   <= '0;
              addrCnt <= '0;
              state   <= IDLE;
            end else begin
              wrCnt <= wrCnt + 1'b1;
            end
          end
        end
        READ: begin
          if (bus.i_valid) begin
            if (addrCnt == lastIdx) begin
              addrCnt     <= '0;
              changeBlock <= 1'b1;
              eop         <= 1'b0;
              state       <= IDLE;
            end else begin
              addrCnt <= addrCnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Load write strobe follows the host beat directly; everything else is a register.
  assign bus.o_wr_en         = (state == LOAD) ? bus.i_valid : pipeOut;
  assign bus.o_writeAdd      = (state == LOAD) ? addrCnt : wrCnt;
  assign bus.o_readAdd       = (state == LOAD) ? '0 : addrCnt;
  assign bus.o_valid_conv    = validConv;
  assign bus.o_bank_sel      = bankSel;
  assign bus.o_changeBlock   = changeBlock;
  assign bus.o_EoP           = eop;
  assign bus.o_busy          = (state != IDLE);
  assign bus.o_state         = state;

endmodule

// File: tb/tb_conv_addr_sequencer.sv
// Directed/randomised bench for conv_addr_sequencer: a LATENCY=6 instance for the
// main flows and a LATENCY=1 instance for the single-word boundary case.
module tb_conv_addr_sequencer;
  logic i_CLK   = 1'b0;
  logic i_reset = 1'b1;
  int   nAsserts = 0;
  int   nFails   = 0;
  int   loadCount [2];
  int   lat [2];

  logic       loadI [2];
  logic       sopI [2];
  logic       readI [2];
  logic       validI [2];
  logic [9:0] lenI [2];
  logic [2:0] stateO [2];
  logic [9:0] rdO [2];
  logic [9:0] wrAddO [2];
  logic       wrEnO [2];
  logic       vcO [2];
  logic       cbO [2];
  logic       eopO [2];
  logic       busyO [2];
  logic [1:0] bankO [2];

  always #5 i_CLK = ~i_CLK;

  conv_addr_sequencer_if #(.NB_ADDRESS(10), .NB_IMAGE(10), .NB_BANK(2)) bus0 ();
  conv_addr_sequencer_if #(.NB_ADDRESS(10), .NB_IMAGE(10), .NB_BANK(2)) bus1 ();

  conv_addr_sequencer #(.NB_ADDRESS(10), .NB_IMAGE(10), .N_BANKS(3), .LATENCY(6))
    dut0 (.i_CLK(i_CLK), .i_reset(i_reset), .bus(bus0));
  conv_addr_sequencer #(.NB_ADDRESS(10), .NB_IMAGE(10), .N_BANKS(3), .LATENCY(1))
    dut1 (.i_CLK(i_CLK), .i_reset(i_reset), .bus(bus1));

  assign bus0.i_load = loadI[0];  assign bus1.i_load = loadI[1];
  assign bus0.i_SoP  = sopI[0];   assign bus1.i_SoP  = sopI[1];
  assign bus0.i_read = readI[0];  assign bus1.i_read = readI[1];
  assign bus0.i_valid = validI[0]; assign bus1.i_valid = validI[1];
  assign bus0.i_imgLength = lenI[0]; assign bus1.i_imgLength = lenI[1];
  assign stateO[0] = bus0.o_state;     assign stateO[1] = bus1.o_state;
  assign rdO[0]    = bus0.o_readAdd;   assign rdO[1]    = bus1.o_readAdd;
  assign wrAddO[0] = bus0.o_writeAdd;  assign wrAddO[1] = bus1.o_writeAdd;
  assign wrEnO[0]  = bus0.o_wr_en;     assign wrEnO[1]  = bus1.o_wr_en;
  assign vcO[0]    = bus0.o_valid_conv; assign vcO[1]   = bus1.o_valid_conv;
  assign cbO[0]    = bus0.o_changeBlock; assign cbO[1]  = bus1.o_changeBlock;
  assign eopO[0]   = bus0.o_EoP;       assign eopO[1]   = bus1.o_EoP;
  assign busyO[0]  = bus0.o_busy;      assign busyO[1]  = bus1.o_busy;
  assign bankO[0]  = bus0.o_bank_sel;  assign bankO[1]  = bus1.o_bank_sel;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 2 time units after a rising edge; checks happen 1 unit later.
  task automatic cyc();
    @(posedge i_CLK);
    #2;
  endtask

  task automatic runLoad(input int sel, input int len);
    int beat;
    int n;
    logic v;
    n = len + 1;
    beat = 0;
    lenI[sel] = 10'(len);
    loadI[sel] = 1'b1;
    #1;
    check($sformatf("load%0d_bank_before", sel), 32'(bankO[sel]), 32'(loadCount[sel] % 3));
    cyc();
    for (int c = 0; c < 400 && beat < n; c++) begin
      v = ($urandom_range(0, 3) != 0);
      validI[sel] = v;
      loadI[sel] = 1'($urandom_range(0, 1));
      #1;
      check($sformatf("load%0d_state", sel), 32'(stateO[sel]), 32'd1);
      check($sformatf("load%0d_wr_en", sel), 32'(wrEnO[sel]), 32'(v));
      check($sformatf("load%0d_writeAdd", sel), 32'(wrAddO[sel]), 32'(beat));
      check($sformatf("load%0d_cb_low", sel), 32'(cbO[sel]), 32'd0);
      cyc();
      if (v) beat++;
    end
    validI[sel] = 1'b0;
    loadI[sel] = 1'b0;
    loadCount[sel]++;
    #1;
    check($sformatf("load%0d_beats_done", sel), 32'(beat), 32'(n));
    check($sformatf("load%0d_cb_pulse", sel), 32'(cbO[sel]), 32'd1);
    check($sformatf("load%0d_idle", sel), 32'(stateO[sel]), 32'd0);
    check($sformatf("load%0d_bank_after", sel), 32'(bankO[sel]), 32'(loadCount[sel] % 3));
    cyc();
    #1;
    check($sformatf("load%0d_cb_width", sel), 32'(cbO[sel]), 32'd0);
    cyc();
  endtask

  task automatic runProc(input int sel, input int len);
    int n;
    int l;
    int expRd;
    n = len + 1;
    l = lat[sel];
    lenI[sel] = 10'(len);
    sopI[sel] = 1'b1;
    #1;
    check($sformatf("proc%0d_entry_idle", sel), 32'(stateO[sel]), 32'd0);
    cyc();
    sopI[sel] = 1'b0;
    for (int k = 0; k <= n + l; k++) begin
      if (k == 2) lenI[sel] = 10'(len) ^ 10'h155;
      #1;
      expRd = (k == n + l) ? 0 : ((k < n) ? k : n - 1);
      check($sformatf("proc%0d_state_k%0d", sel, k), 32'(stateO[sel]),
            32'((k < n) ? 2 : ((k < n + l) ? 3 : 0)));
      check($sformatf("proc%0d_valid_conv_k%0d", sel, k), 32'(vcO[sel]), 32'(k < n));
      check($sformatf("proc%0d_readAdd_k%0d", sel, k), 32'(rdO[sel]), 32'(expRd));
      check($sformatf("proc%0d_wr_en_k%0d", sel, k), 32'(wrEnO[sel]), 32'(k >= l && k < l + n));
      if (k >= l && k < l + n)
        check($sformatf("proc%0d_writeAdd_k%0d", sel, k), 32'(wrAddO[sel]), 32'(k - l));
      check($sformatf("proc%0d_EoP_k%0d", sel, k), 32'(eopO[sel]), 32'(k == n + l));
      check($sformatf("proc%0d_cb_k%0d", sel, k), 32'(cbO[sel]), 32'd0);
      cyc();
    end
  endtask

  task automatic runRead(input int sel, input int len);
    int beat;
    int n;
    logic v;
    n = len + 1;
    beat = 0;
    lenI[sel] = 10'(len);
    readI[sel] = 1'b1;
    #1;
    check($sformatf("read%0d_eop_before", sel), 32'(eopO[sel]), 32'd1);
    cyc();
    readI[sel] = 1'b0;
    for (int c = 0; c < 400 && beat < n; c++) begin
      v = ($urandom_range(0, 3) != 0);
      validI[sel] = v;
      #1;
      check($sformatf("read%0d_state", sel), 32'(stateO[sel]), 32'd4);
      check($sformatf("read%0d_readAdd", sel), 32'(rdO[sel]), 32'(beat));
      check($sformatf("read%0d_wr_en", sel), 32'(wrEnO[sel]), 32'd0);
      check($sformatf("read%0d_eop_held", sel), 32'(eopO[sel]), 32'd1);
      check($sformatf("read%0d_cb_low", sel), 32'(cbO[sel]), 32'd0);
      cyc();
      if (v) beat++;
    end
    validI[sel] = 1'b0;
    #1;
    check($sformatf("read%0d_beats_done", sel), 32'(beat), 32'(n));
    check($sformatf("read%0d_cb_pulse", sel), 32'(cbO[sel]), 32'd1);
    check($sformatf("read%0d_eop_fall", sel), 32'(eopO[sel]), 32'd0);
    check($sformatf("read%0d_idle", sel), 32'(stateO[sel]), 32'd0);
    cyc();
    #1;
    check($sformatf("read%0d_cb_width", sel), 32'(cbO[sel]), 32'd0);
    cyc();
  endtask

  task automatic arb(input int sel, input logic l, input logic s, input logic r,
                     input logic expEop, input string tag);
    loadI[sel] = l;
    sopI[sel]  = s;
    readI[sel] = r;
    cyc();
    loadI[sel] = 1'b0;
    sopI[sel]  = 1'b0;
    readI[sel] = 1'b0;
    #1;
    check({tag, "_state"}, 32'(stateO[sel]), 32'd0);
    check({tag, "_busy"}, 32'(busyO[sel]), 32'd0);
    check({tag, "_eop"}, 32'(eopO[sel]), 32'(expEop));
    cyc();
  endtask

  initial begin
    int len;
    lat[0] = 6;
    lat[1] = 1;
    for (int i = 0; i < 2; i++) begin
      loadCount[i] = 0;
      loadI[i] = 1'b0;
      sopI[i] = 1'b0;
      readI[i] = 1'b0;
      validI[i] = 1'b0;
      lenI[i] = 10'd7;
    end

    repeat (2) @(posedge i_CLK);
    #2;
    i_reset = 1'b0;
    #1;
    check("rst_state", 32'(stateO[0]), 32'd0);
    check("rst_bank", 32'(bankO[0]), 32'd0);
    check("rst_eop", 32'(eopO[0]), 32'd0);
    check("rst_busy", 32'(busyO[0]), 32'd0);
    check("rst_wr_en", 32'(wrEnO[0]), 32'd0);
    check("rst_valid_conv", 32'(vcO[0]), 32'd0);
    cyc();

    for (int i = 0; i < 3; i++) runLoad(0, 7);

    arb(0, 1'b1, 1'b1, 1'b0, 1'b0, "arb_load_sop");
    arb(0, 1'b0, 1'b0, 1'b1, 1'b0, "arb_read_noeop");
    arb(0, 1'b1, 1'b0, 1'b1, 1'b0, "arb_load_read");

    runProc(0, 7);

    arb(0, 1'b1, 1'b0, 1'b0, 1'b1, "arb_load_eop");
    arb(0, 1'b0, 1'b1, 1'b0, 1'b1, "arb_sop_eop");
    arb(0, 1'b0, 1'b1, 1'b1, 1'b1, "arb_sop_read");

    runRead(0, 7);

    for (int r = 0; r < 4; r++) begin
      len = $urandom_range(0, 20);
      runLoad(0, len);
      runProc(0, len);
      runRead(0, len);
    end

    runLoad(1, 0);
    runProc(1, 0);
    runRead(1, 0);

    // Asynchronous reset in the middle of a process phase, with a non-zero bank.
    if (loadCount[0] % 3 == 0) runLoad(0, 3);
    lenI[0] = 10'd7;
    sopI[0] = 1'b1;
    cyc();
    sopI[0] = 1'b0;
    repeat (3) cyc();
    #1;
    check("pre_rst_state_proc", 32'(stateO[0]), 32'd2);
    i_reset = 1'b1;
    #1;
    check("async_rst_state", 32'(stateO[0]), 32'd0);
    check("async_rst_busy", 32'(busyO[0]), 32'd0);
    check("async_rst_valid_conv", 32'(vcO[0]), 32'd0);
    check("async_rst_readAdd", 32'(rdO[0]), 32'd0);
    check("async_rst_writeAdd", 32'(wrAddO[0]), 32'd0);
    check("async_rst_wr_en", 32'(wrEnO[0]), 32'd0);
    check("async_rst_bank", 32'(bankO[0]), 32'd0);
    check("async_rst_eop", 32'(eopO[0]), 32'd0);
    check("async_rst_cb", 32'(cbO[0]), 32'd0);
    #1;
    i_reset = 1'b0;
    loadCount[0] = 0;
    loadCount[1] = 0;
    cyc();
    #1;
    check("post_rst_state", 32'(stateO[0]), 32'd0);
    check("post_rst_bank", 32'(bankO[0]), 32'd0);
    check("post_rst_eop", 32'(eopO[0]), 32'd0);
    check("post_rst_wr_en", 32'(wrEnO[0]), 32'd0);
    cyc();
    runLoad(0, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end
endmodule

// File: doc/conv_addr_sequencer.md
Name: conv_addr_sequencer

Overview:
- Parametrised address/phase controller for the 2D-convolution datapath; next generation of the single-image FSM.
- Sequences three phases: block load into N_BANKS rotating line banks, convolution processing with a configurable pipeline latency, and result readout.
- Drives read/write addresses, write enable, convolver valid, bank select and phase flags.
- Sits between the host/control registers and the line memories plus convolver.

Parameters:
- NB_ADDRESS, 10, address width.
- NB_IMAGE, 10, width of i_imgLength.
- N_BANKS, 3, number of line banks rotated on load (>=1).
- LATENCY, 6, convolver pipeline depth in cycles, read issue to result write (>=1).
- NB_BANK, clog2(N_BANKS) (min 1), width of o_bank_sel.

Ports:
- i_CLK  in  1  clock, rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_load  in  1  request load phase.
- i_SoP  in  1  start-of-process request.
- i_read  in  1  request readout phase.
- i_valid  in  1  host data beat during load/readout.
- i_imgLength  in  NB_IMAGE  last address index; block size N = i_imgLength+1.
- o_readAdd  out  NB_ADDRESS  read address.
- o_writeAdd  out  NB_ADDRESS  write address.
- o_wr_en  out  1  write enable for bank (load) or result memory (process).
- o_valid_conv  out  1  data valid to convolver.
- o_bank_sel  out  NB_BANK  bank receiving the current/next load.
- o_changeBlock  out  1  one-cycle pulse at end of each load/readout block.
- o_EoP  out  1  result ready; high from process completion until readout done.
- o_busy  out  1  state != IDLE.
- o_state  out  3  current state, debug.

Behaviour:
- Reset: asserting i_reset immediately (no clock edge) zeroes every register and output: state=IDLE, counters, bank_sel, EoP, pipeline shift register. Mid-operation reset aborts the phase with no completion pulse.
- Outputs are registered. o_wr_en in LOAD equals i_valid combinationally.
- States: IDLE=0, LOAD=1, PROC=2, DRAIN=3, READ=4.
- i_imgLength is latched on leaving IDLE. Changes during a phase are ignored.
- IDLE: counters held at 0. Accepts exactly one request:
  - i_load alone with EoP=0 -> LOAD.
  - i_SoP alone with EoP=0 -> PROC.
  - i_read alone with EoP=1 -> READ.
  - Any other combination (multiple requests, load/SoP while EoP=1, read while EoP=0) stays in IDLE.
- LOAD: o_writeAdd = counter; o_wr_en = i_valid; counter += 1 per beat. The beat at counter==N-1:
  - pulses o_changeBlock the next cycle;
  - advances bank_sel mod N_BANKS (N_BANKS-1 wraps to 0);
  - clears the counter and returns to IDLE.
  - i_load level is ignored after entry.
- PROC: on cycle k (k=0 is the first PROC cycle), o_readAdd=k and o_valid_conv=1 for k=0..N-1. On the cycle k=N-1 is issued, transition to DRAIN. o_valid_conv=0 from the first DRAIN cycle.
- Write path: a LATENCY-deep valid shift register feeds the write counter. o_wr_en=1 with o_writeAdd=k on cycle k+LATENCY. o_readAdd holds N-1 in DRAIN.
- DRAIN: when the write of index N-1 occurs, o_EoP is set and state returns to IDLE on the next cycle. Total: EoP first high on cycle N+LATENCY.
- READ: o_readAdd = counter; counter += 1 per i_valid beat; o_wr_en=0. The beat at N-1:
  - pulses o_changeBlock the next cycle;
  - clears o_EoP in that same cycle;
  - returns to IDLE.
- Width rules: counters are NB_ADDRESS wide. i_imgLength is zero-extended or truncated to NB_ADDRESS. i_imgLength=0 gives a one-word block. Counter never wraps within a phase.
- o_changeBlock is exactly one cycle wide; never asserted in PROC/DRAIN.

Test Plan:
- Async reset: assert i_reset mid-PROC between clock edges -> all outputs 0 before next edge; after release o_state=0, o_bank_sel=0, o_EoP=0.
- Load rotation: N_BANKS=3, i_imgLength=7, three loads of 8 beats with random i_valid gaps -> o_writeAdd 0..7 with o_wr_en on each beat; o_changeBlock pulse after each 8th beat; o_bank_sel 0->1->2->0.
- Process timing: i_imgLength=7, LATENCY=6, pulse i_SoP ->
  - o_valid_conv high cycles 0..7 with o_readAdd 0..7;
  - o_wr_en high cycles 6..13 with o_writeAdd 0..7;
  - o_EoP rises cycle 14.
- Readout: after EoP, pulse i_read then 8 i_valid beats -> o_readAdd 0..7; o_changeBlock pulse and o_EoP falls one cycle after the 8th beat.
- Request arbitration: i_load and i_SoP together -> stays IDLE; i_SoP or i_load while o_EoP=1 -> ignored; i_read while o_EoP=0 -> ignored.
- Boundaries: i_imgLength=0, LATENCY=1 -> one read at cycle 0, one write (addr 0) at cycle 1, o_EoP at cycle 2; i_imgLength change mid-PROC has no effect.
